// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: decode, ID_EX/EX_MEM/MEM_WB control registers, load-use hazard.
// Optional perf counters under `PIPE_CTRL_PERF_EN.
module pipe_ctrl_unit #(
  parameter int RD_W      = 5,
  parameter int ALUSRCB_W = 3,
  parameter int PERF_W    = 32
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [6:0]           opcode,
  input  logic [RD_W-1:0]      rs1,
  input  logic [RD_W-1:0]      rs2,
  input  logic [RD_W-1:0]      rd,
  input  logic                 in_valid,
  input  logic                 flush,
  input  logic                 ext_stall,
  output logic                 hazard_stall,
  output logic                 illegal,
  output logic                 RegWrite_ID_EX,
  output logic                 PCWriteCond_ID_EX,
  output logic                 ALUSrcA_ID_EX,
  output logic                 MemRead_ID_EX,
  output logic                 MemWrite_ID_EX,
  output logic                 MemtoReg_ID_EX,
  output logic                 Jump_ID_EX,
  output logic [ALUSRCB_W-1:0] ALUSrcB_ID_EX,
  output logic                 Valid_ID_EX,
  output logic [RD_W-1:0]      Rd_ID_EX,
  output logic                 RegWrite_EX_MEM,
  output logic                 PCWriteCond_EX_MEM,
  output logic                 MemRead_EX_MEM,
  output logic                 MemWrite_EX_MEM,
  output logic                 MemtoReg_EX_MEM,
  output logic                 Valid_EX_MEM,
  output logic [RD_W-1:0]      Rd_EX_MEM,
`ifdef PIPE_CTRL_PERF_EN
  output logic [PERF_W-1:0]    bubble_cnt,
  output logic [PERF_W-1:0]    flush_cnt,
  output logic [PERF_W-1:0]    retire_cnt,
`endif
  output logic                 RegWrite_MEM_WB,
  output logic                 MemtoReg_MEM_WB,
  output logic                 Valid_MEM_WB,
  output logic [RD_W-1:0]      Rd_MEM_WB
);

  typedef struct packed {
    logic                 rw;
    logic                 pwc;
    logic                 asa;
    logic                 mr;
    logic                 mw;
    logic                 m2r;
    logic                 jmp;
    logic [ALUSRCB_W-1:0] asb;
    logic                 vld;
    logic [RD_W-1:0]      rd;
  } id_ex_t;

  typedef struct packed {
    logic            rw;
    logic            pwc;
    logic            mr;
    logic            mw;
    logic            m2r;
    logic            vld;
    logic [RD_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic            rw;
    logic            m2r;
    logic            vld;
    logic [RD_W-1:0] rd;
  } mem_wb_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  id_ex_t  r_idex;
  ex_mem_t r_exmem;
  mem_wb_t r_memwb;

  id_ex_t  w_dec;
  logic    w_known;
  logic    w_rs2_use;
  logic    w_rs1_hit;
  logic    w_rs2_hit;

  always_comb begin
    w_dec   = '0;
    w_known = 1'b1;
    unique case (1'b1)
      (opcode == OP_R): begin
        w_dec.rw  = 1'b1;
        w_dec.asb = ALUSRCB_W'(0);
      end
      (opcode == OP_I): begin
        w_dec.rw  = 1'b1;
        w_dec.asb = ALUSRCB_W'(2);
      end
      (opcode == OP_LD): begin
        w_dec.rw  = 1'b1;
        w_dec.mr  = 1'b1;
        w_dec.m2r = 1'b1;
        w_dec.asb = ALUSRCB_W'(2);
      end
      (opcode == OP_ST): begin
        w_dec.mw  = 1'b1;
        w_dec.asb = ALUSRCB_W'(3);
      end
      (opcode == OP_JAL),
      (opcode == OP_JALR): begin
        w_dec.rw  = 1'b1;
        w_dec.jmp = 1'b1;
        w_dec.asa = 1'b1;
        w_dec.asb = ALUSRCB_W'(1);
      end
      (opcode == OP_BR): begin
        w_dec.pwc = 1'b1;
        w_dec.asb = ALUSRCB_W'(0);
      end
      (opcode == OP_LUI): begin
        w_dec.rw  = 1'b1;
        w_dec.asb = ALUSRCB_W'(4);
      end
      (opcode == OP_AUI): begin
        w_dec.rw  = 1'b1;
        w_dec.asa = 1'b1;
        w_dec.asb = ALUSRCB_W'(4);
      end
      default: w_known = 1'b0;
    endcase
    // Idle slots and undecoded opcodes collapse to a bubble
    if (!(in_valid && w_known)) begin
      w_dec = '0;
    end else begin
      w_dec.vld = 1'b1;
      w_dec.rd  = rd;
      if (rd == '0) w_dec.rw = 1'b0;
    end
  end

  assign illegal   = in_valid & ~w_known;
  assign w_rs2_use = (opcode == OP_R) | (opcode == OP_ST) |
                     (opcode == OP_BR);
  assign w_rs1_hit = (r_idex.rd == rs1);
  assign w_rs2_hit = (r_idex.rd == rs2) & w_rs2_use;

  assign hazard_stall = r_idex.vld & r_idex.mr &
                        (r_idex.rd != '0) & in_valid &
                        (w_rs1_hit | w_rs2_hit);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_idex  <= '0;
      r_exmem <= '0;
      r_memwb <= '0;
    end else if (!ext_stall) begin
      if (flush) begin
        r_idex  <= '0;
        r_exmem <= '0;
      end else begin
        r_idex        <= hazard_stall ? '0 : w_dec;
        r_exmem.rw    <= r_idex.rw;
        r_exmem.pwc   <= r_idex.pwc;
        r_exmem.mr    <= r_idex.mr;
        r_exmem.mw    <= r_idex.mw;
        r_exmem.m2r   <= r_idex.m2r;
        r_exmem.vld   <= r_idex.vld;
        r_exmem.rd    <= r_idex.rd;
      end
      r_memwb.rw  <= r_exmem.rw;
      r_memwb.m2r <= r_exmem.m2r;
      r_memwb.vld <= r_exmem.vld;
      r_memwb.rd  <= r_exmem.rd;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] r_bubble_cnt;
  logic [PERF_W-1:0] r_flush_cnt;
  logic [PERF_W-1:0] r_retire_cnt;

  // A bubble is only charged to the hazard when flush is not the cause
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
      r_retire_cnt <= '0;
    end else if (!ext_stall) begin
      if (hazard_stall && !flush) r_bubble_cnt <= r_bubble_cnt + 1'b1;
      if (flush)                  r_flush_cnt  <= r_flush_cnt + 1'b1;
      if (r_memwb.vld)            r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign retire_cnt = r_retire_cnt;
`else
  logic w_unused_perf;
  assign w_unused_perf = (PERF_W > 0);
`endif

  assign RegWrite_ID_EX     = r_idex.rw;
  assign PCWriteCond_ID_EX  = r_idex.pwc;
  assign ALUSrcA_ID_EX      = r_idex.asa;
  assign MemRead_ID_EX      = r_idex.mr;
  assign MemWrite_ID_EX     = r_idex.mw;
  assign MemtoReg_ID_EX     = r_idex.m2r;
  assign Jump_ID_EX         = r_idex.jmp;
  assign ALUSrcB_ID_EX      = r_idex.asb;
  assign Valid_ID_EX        = r_idex.vld;
  assign Rd_ID_EX           = r_idex.rd;

  assign RegWrite_EX_MEM    = r_exmem.rw;
  assign PCWriteCond_EX_MEM = r_exmem.pwc;
  assign MemRead_EX_MEM     = r_exmem.mr;
  assign MemWrite_EX_MEM    = r_exmem.mw;
  assign MemtoReg_EX_MEM    = r_exmem.m2r;
  assign Valid_EX_MEM       = r_exmem.vld;
  assign Rd_EX_MEM          = r_exmem.rd;

  assign RegWrite_MEM_WB    = r_memwb.rw;
  assign MemtoReg_MEM_WB    = r_memwb.m2r;
  assign Valid_MEM_WB       = r_memwb.vld;
  assign Rd_MEM_WB          = r_memwb.rd;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: decode, pipeline advance, hazards, flush, stall.
// Perf counter checks are active when PIPE_CTRL_PERF_EN is defined.
module tb_pipe_ctrl_unit;

  localparam int RD_W   = 5;
  localparam int ASB_W  = 3;
  localparam int PERF_W = 4;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_AUI  = 7'b0010111;

  logic            CLK;
  logic            RSTn;
  logic [6:0]      opcode;
  logic [RD_W-1:0] rs1, rs2, rd;
  logic            in_valid, flush, ext_stall;
  logic            hazard_stall, illegal;
  logic            RegWrite_ID_EX, PCWriteCond_ID_EX, ALUSrcA_ID_EX;
  logic            MemRead_ID_EX, MemWrite_ID_EX, MemtoReg_ID_EX;
  logic            Jump_ID_EX, Valid_ID_EX;
  logic [ASB_W-1:0] ALUSrcB_ID_EX;
  logic [RD_W-1:0] Rd_ID_EX;
  logic            RegWrite_EX_MEM, PCWriteCond_EX_MEM, MemRead_EX_MEM;
  logic            MemWrite_EX_MEM, MemtoReg_EX_MEM, Valid_EX_MEM;
  logic [RD_W-1:0] Rd_EX_MEM;
  logic            RegWrite_MEM_WB, MemtoReg_MEM_WB, Valid_MEM_WB;
  logic [RD_W-1:0] Rd_MEM_WB;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] bubble_cnt, flush_cnt, retire_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  pipe_ctrl_unit #(
    .RD_W(RD_W), .ALUSRCB_W(ASB_W), .PERF_W(PERF_W)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .in_valid(in_valid), .flush(flush), .ext_stall(ext_stall),
    .hazard_stall(hazard_stall), .illegal(illegal),
    .RegWrite_ID_EX(RegWrite_ID_EX),
    .PCWriteCond_ID_EX(PCWriteCond_ID_EX),
    .ALUSrcA_ID_EX(ALUSrcA_ID_EX),
    .MemRead_ID_EX(MemRead_ID_EX),
    .MemWrite_ID_EX(MemWrite_ID_EX),
    .MemtoReg_ID_EX(MemtoReg_ID_EX),
    .Jump_ID_EX(Jump_ID_EX),
    .ALUSrcB_ID_EX(ALUSrcB_ID_EX),
    .Valid_ID_EX(Valid_ID_EX), .Rd_ID_EX(Rd_ID_EX),
    .RegWrite_EX_MEM(RegWrite_EX_MEM),
    .PCWriteCond_EX_MEM(PCWriteCond_EX_MEM),
    .MemRead_EX_MEM(MemRead_EX_MEM),
    .MemWrite_EX_MEM(MemWrite_EX_MEM),
    .MemtoReg_EX_MEM(MemtoReg_EX_MEM),
    .Valid_EX_MEM(Valid_EX_MEM), .Rd_EX_MEM(Rd_EX_MEM),
`ifdef PIPE_CTRL_PERF_EN
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt),
    .retire_cnt(retire_cnt),
`endif
    .RegWrite_MEM_WB(RegWrite_MEM_WB),
    .MemtoReg_MEM_WB(MemtoReg_MEM_WB),
    .Valid_MEM_WB(Valid_MEM_WB), .Rd_MEM_WB(Rd_MEM_WB)
  );

  logic [6:0] w_idex_fl;
  logic [34:0] w_all;
  assign w_idex_fl = {RegWrite_ID_EX, PCWriteCond_ID_EX,
                      ALUSrcA_ID_EX, MemRead_ID_EX, MemWrite_ID_EX,
                      MemtoReg_ID_EX, Jump_ID_EX};
  assign w_all = {w_idex_fl, ALUSrcB_ID_EX, Valid_ID_EX, Rd_ID_EX,
                  RegWrite_EX_MEM, PCWriteCond_EX_MEM, MemRead_EX_MEM,
                  MemWrite_EX_MEM, MemtoReg_EX_MEM, Valid_EX_MEM,
                  Rd_EX_MEM, RegWrite_MEM_WB, MemtoReg_MEM_WB,
                  Valid_MEM_WB, Rd_MEM_WB};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [RD_W-1:0] a,
                       input logic [RD_W-1:0] b, input logic [RD_W-1:0] d,
                       input logic v);
    opcode   = op;
    rs1      = a;
    rs2      = b;
    rd       = d;
    in_valid = v;
  endtask

  // {RegWrite,PCWriteCond,ALUSrcA,MemRead,MemWrite,MemtoReg,Jump}, ALUSrcB
  logic [6:0] sw_op [9] = '{OP_R, OP_I, OP_LD, OP_ST, OP_JAL, OP_JALR,
                            OP_BR, OP_LUI, OP_AUI};
  logic [6:0] sw_fl [9] = '{7'b1000000, 7'b1000000, 7'b1001010,
                            7'b0000100, 7'b1010001, 7'b1010001,
                            7'b0100000, 7'b1000000, 7'b1010000};
  logic [2:0] sw_b  [9] = '{3'd0, 3'd2, 3'd2, 3'd3, 3'd1, 3'd1,
                            3'd0, 3'd4, 3'd4};

  initial begin
    RSTn      = 1'b0;
    flush     = 1'b0;
    ext_stall = 1'b0;
    drive(7'd0, '0, '0, '0, 1'b0);
    step();
    step();
    chk("reset_all", 64'(w_all), 64'd0);
    RSTn = 1'b1;
    step();
    chk("idle_all", 64'(w_all), 64'd0);

    for (int i = 0; i < 9; i++) begin
      drive(sw_op[i], 5'd0, 5'd0, 5'd3, 1'b1);
      #1;
      chk($sformatf("dec_ill_%0d", i), 64'(illegal), 64'd0);
      step();
      chk($sformatf("dec_fl_%0d", i), 64'(w_idex_fl), 64'(sw_fl[i]));
      chk($sformatf("dec_b_%0d", i), 64'(ALUSrcB_ID_EX), 64'(sw_b[i]));
      chk($sformatf("dec_vr_%0d", i), 64'({Valid_ID_EX, Rd_ID_EX}),
          64'({1'b1, 5'd3}));
    end

    drive(7'b1111111, 5'd0, 5'd0, 5'd3, 1'b1);
    #1;
    chk("illegal", 64'(illegal), 64'd1);
    step();
    chk("illegal_bub", 64'({Valid_ID_EX, Rd_ID_EX, w_idex_fl}), 64'd0);

    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
    chk("x0_guard_rw", 64'(RegWrite_ID_EX), 64'd0);
    chk("x0_guard_vld", 64'(Valid_ID_EX), 64'd1);

    // async reset between edges
    drive(OP_R, 5'd0, 5'd0, 5'd9, 1'b1);
    step();
    #2 RSTn = 1'b0;
    #1;
    chk("midrst_now", 64'(w_all), 64'd0);
    step();
    chk("midrst_hold", 64'(w_all), 64'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_rst", 64'({bubble_cnt, flush_cnt, retire_cnt}), 64'd0);
`endif
    RSTn = 1'b1;
    drive(OP_LD, 5'd0, 5'd0, 5'd5, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    chk("lat_e2", 64'(Valid_MEM_WB), 64'd0);
    step();
    chk("lat_e3", 64'({Valid_MEM_WB, Rd_MEM_WB, MemtoReg_MEM_WB}),
        64'({1'b1, 5'd5, 1'b1}));

    // load-use on rs1
    drive(OP_LD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd0, 5'd8, 1'b1);
    #1;
    chk("lu_rs1_stall", 64'(hazard_stall), 64'd1);
    step();
    chk("lu_rs1_bub", 64'(Valid_ID_EX), 64'd0);
    chk("lu_rs1_exm", 64'({MemRead_EX_MEM, Rd_EX_MEM}),
        64'({1'b1, 5'd7}));
    chk("lu_rs1_clr", 64'(hazard_stall), 64'd0);
    step();
    chk("lu_rs1_go", 64'({Valid_ID_EX, RegWrite_ID_EX, Rd_ID_EX}),
        64'({1'b1, 1'b1, 5'd8}));

    // load-use on rs2 of a store; I-type ignores rs2
    drive(OP_LD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_I, 5'd1, 5'd7, 5'd2, 1'b1);
    #1;
    chk("lu_itype_rs2", 64'(hazard_stall), 64'd0);
    drive(OP_ST, 5'd1, 5'd7, 5'd0, 1'b1);
    #1;
    chk("lu_st_rs2", 64'(hazard_stall), 64'd1);
    step();
    chk("lu_st_bub", 64'(Valid_ID_EX), 64'd0);
    step();
    chk("lu_st_go", 64'({Valid_ID_EX, MemWrite_ID_EX}), 64'd3);

    // load to x0 never stalls
    drive(OP_LD, 5'd0, 5'd0, 5'd0, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd4, 1'b1);
    #1;
    chk("lu_x0", 64'(hazard_stall), 64'd0);
    drive(OP_LD, 5'd0, 5'd0, 5'd6, 1'b1);
    step();
    drive(OP_R, 5'd6, 5'd0, 5'd4, 1'b0);
    #1;
    chk("lu_novalid", 64'(hazard_stall), 64'd0);

    // flush
    drive(OP_R, 5'd0, 5'd0, 5'd10, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd11, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd12, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_idex", 64'(Valid_ID_EX), 64'd0);
    chk("fl_exmem", 64'(Valid_EX_MEM), 64'd0);
    chk("fl_memwb", 64'({Valid_MEM_WB, Rd_MEM_WB}), 64'({1'b1, 5'd10}));

    // ext_stall overrides flush and hazard
    drive(OP_R, 5'd0, 5'd0, 5'd20, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd21, 1'b1);
    step();
    drive(OP_LD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd0, 5'd9, 1'b1);
    flush     = 1'b1;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("es_idex_%0d", i),
          64'({Valid_ID_EX, MemRead_ID_EX, Rd_ID_EX}),
          64'({1'b1, 1'b1, 5'd7}));
      chk($sformatf("es_exmem_%0d", i), 64'(Rd_EX_MEM), 64'd21);
      chk($sformatf("es_memwb_%0d", i), 64'(Rd_MEM_WB), 64'd20);
      chk($sformatf("es_haz_%0d", i), 64'(hazard_stall), 64'd1);
    end
    ext_stall = 1'b0;
    flush     = 1'b0;
    step();
    chk("es_rel_idex", 64'(Valid_ID_EX), 64'd0);
    chk("es_rel_exmem", 64'({MemRead_EX_MEM, Rd_EX_MEM}),
        64'({1'b1, 5'd7}));
    chk("es_rel_memwb", 64'(Rd_MEM_WB), 64'd21);
    step();
    chk("es_rel_add", 64'({Valid_ID_EX, Rd_ID_EX}), 64'({1'b1, 5'd9}));

    // counter scenario: 2 stalls, 1 flush, 5 then 17 retirements
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    #2 RSTn = 1'b0;
    #1 RSTn = 1'b1;
    drive(OP_LD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_R, 5'd7, 5'd0, 5'd8, 1'b1);
    step();
    step();
    drive(OP_LD, 5'd0, 5'd0, 5'd7, 1'b1);
    step();
    drive(OP_ST, 5'd1, 5'd7, 5'd0, 1'b1);
    step();
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (4) step();
    chk("pc_drain", 64'(w_all), 64'd0);
    drive(OP_R, 5'd0, 5'd0, 5'd1, 1'b1);
    step();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_bubble", 64'(bubble_cnt), 64'd2);
    chk("perf_flush", 64'(flush_cnt), 64'd1);
    chk("perf_retire5", 64'(retire_cnt), 64'd5);
`endif
    drive(OP_R, 5'd0, 5'd0, 5'd1, 1'b1);
    repeat (12) step();
    drive(OP_R, 5'd0, 5'd0, 5'd0, 1'b0);
    repeat (4) step();
    chk("pc_drain2", 64'(Valid_MEM_WB), 64'd0);
`ifdef PIPE_CTRL_PERF_EN
    chk("perf_wrap", 64'(retire_cnt), 64'd1);
    chk("perf_bubble2", 64'(bubble_cnt), 64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Successor control unit for the 5-stage RV32I pipeline. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID_EX, EX_MEM and MEM_WB pipeline registers, each with a valid bit and a destination register. It detects load-use hazards, inserts bubbles, and honours branch flush and global stall. It sits between the IF/ID register and the datapath stage muxes.

Parameters:
RD_W, 5, register-index width for rs1/rs2/rd
ALUSRCB_W, 3, width of the ALUSrcB select; must be >= 3
PERF_W, 32, width of the performance counters (optional feature only)

Ports:
CLK  in  1  clock, all state updates on posedge
RSTn  in  1  asynchronous active-low reset
opcode  in  7  ID-stage instruction opcode
rs1  in  RD_W  ID-stage source register 1
rs2  in  RD_W  ID-stage source register 2
rd  in  RD_W  ID-stage destination register
in_valid  in  1  ID-stage holds a real instruction
flush  in  1  branch/jump taken; kill younger instructions
ext_stall  in  1  freeze the whole pipeline (e.g. memory wait)
hazard_stall  out  1  combinational load-use stall request to the IF/ID register and PC
illegal  out  1  combinational: in_valid with an undecoded opcode
RegWrite_ID_EX, PCWriteCond_ID_EX, ALUSrcA_ID_EX, MemRead_ID_EX, MemWrite_ID_EX, MemtoReg_ID_EX, Jump_ID_EX  out  1 each  ID_EX control
ALUSrcB_ID_EX  out  ALUSRCB_W  ID_EX ALU B select
Valid_ID_EX  out  1;  Rd_ID_EX  out  RD_W
RegWrite_EX_MEM, PCWriteCond_EX_MEM, MemRead_EX_MEM, MemWrite_EX_MEM, MemtoReg_EX_MEM, Valid_EX_MEM  out  1 each;  Rd_EX_MEM  out  RD_W
RegWrite_MEM_WB, MemtoReg_MEM_WB, Valid_MEM_WB  out  1 each;  Rd_MEM_WB  out  RD_W

Behaviour:
- Reset (RSTn=0, async, also mid-operation): every registered output is 0 immediately and stays 0 while RSTn is low.
- Decode (combinational; all fields 0 unless listed):
  - 0110011: RegWrite, B=0.
  - 0010011: RegWrite, B=2.
  - 0000011: RegWrite, MemRead, MemtoReg, B=2.
  - 0100011: MemWrite, B=3.
  - 1101111 / 1100111: RegWrite, Jump, A=1, B=1.
  - 1100011: PCWriteCond, B=0.
  - 0110111 (LUI): RegWrite, B=4.
  - 0010111 (AUIPC): RegWrite, A=1, B=4.
  - Any other opcode: decodes as a bubble and raises illegal.
- Bubble: all controls 0, Valid=0, Rd=0. A bundle with in_valid=0 is loaded as a bubble.
- Pipeline advance: one stage per cycle. MEM_WB takes RegWrite, MemtoReg, Valid and Rd from EX_MEM. EX_MEM takes its fields from ID_EX. Latency from decode to MEM_WB is 3 cycles.
- Load-use hazard: hazard_stall=1 when all of the following hold:
  - Valid_ID_EX and MemRead_ID_EX are 1.
  - Rd_ID_EX != 0.
  - in_valid is 1.
  - Rd_ID_EX==rs1, or Rd_ID_EX==rs2 with an rs2-using opcode (0110011, 0100011, 1100011).
- Cycle priority, highest first:
  - ext_stall: every register holds. hazard_stall is still driven; flush is ignored, and the requester must hold it.
  - flush: ID_EX and EX_MEM load bubbles; MEM_WB advances normally.
  - hazard_stall: ID_EX loads a bubble; EX_MEM and MEM_WB advance.
  - Otherwise: ID_EX loads the decoded bundle, Valid_ID_EX=in_valid, Rd_ID_EX=rd.
- Write-to-x0 guard: RegWrite is forced to 0 for a decoded bundle with rd==0.
- hazard_stall and illegal depend only on the current inputs and the ID_EX state; they do not depend on ext_stall.

Optional Feature:
PIPE_CTRL_PERF_EN: when defined, adds three outputs, each PERF_W wide:
- bubble_cnt: +1 per non-stalled cycle in which hazard_stall causes a bubble.
- flush_cnt: +1 per non-stalled cycle with flush=1.
- retire_cnt: +1 per non-stalled cycle with Valid_MEM_WB=1.
Counters wrap modulo 2^PERF_W and are cleared by RSTn. When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset mid-stream: apply RSTn=0 asynchronously between edges -> all outputs 0 before the next CLK; after release, an LW (0000011, rd=5) reaches Valid_MEM_WB=1, Rd_MEM_WB=5, MemtoReg_MEM_WB=1 after exactly 3 edges.
- Decode sweep: each listed opcode with rd=3 -> ID_EX fields match the table. Opcode 1111111 -> illegal=1, Valid_ID_EX=0. rd=0 with opcode 0110011 -> RegWrite_ID_EX=0.
- Load-use: LW rd=7, then ADD rs1=7 -> hazard_stall=1 for one cycle; ID_EX becomes a bubble; the ADD enters ID_EX on the next edge. Repeat with SW rs2=7 -> stall. With LW rd=0 -> no stall.
- Flush: with valid instructions in ID_EX and EX_MEM, pulse flush for one cycle -> both become bubbles; the prior EX_MEM content appears in MEM_WB.
- ext_stall with flush and hazard asserted for 3 cycles -> all pipeline registers unchanged; hazard_stall still reflects the hazard; normal advance after release.
- PERF: with PIPE_CTRL_PERF_EN, 2 load-use stalls, 1 flush and 5 retirements -> bubble_cnt=2, flush_cnt=1, retire_cnt=5. With PERF_W=4 and 17 retirements -> retire_cnt=1.
